// File: rtl/dqsw_trainer_pkg.sv
// Shared encodings for the DQSW write-leveling trainer: FSM states, DQS pulse
// patterns and the eye-monitor retry limit.
package dqsw_trainer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_PULSE,
    S_WAIT,
    S_CAPTURE,
    S_DECIDE,
    S_MOVE
  } state_e;

  localparam logic [1:0] TX_PULSE = 2'b01;
  localparam logic [1:0] OE_PULSE = 2'b11;
  localparam logic [1:0] TXOE_IDLE = 2'b00;

  localparam logic [1:0] EYE_RETRY_LIMIT = 2'd3;

endpackage

// File: rtl/dqsw_sample_voter.sv
// Per-tap sample accumulator: counts captured DQ samples and ones, and gives the
// majority vote (ties vote 0) plus a flag marking the final sample of the tap.
module dqsw_sample_voter #(
  parameter int unsigned SAMPLE_COUNT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic capture_i,
  input  logic sample_i,
  output logic vote_o,
  output logic last_o
);

  localparam logic [3:0] LAST_IDX = 4'(SAMPLE_COUNT - 1);
  localparam logic [4:0] THRESH   = 5'(SAMPLE_COUNT);

  logic [3:0] ones_q, ones_d;
  logic [3:0] samples_q, samples_d;

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ones_d    = ones_q;
    samples_d = samples_q;
    if (clear_i) begin
      ones_d    = '0;
      samples_d = '0;
    end else if (capture_i) begin
      ones_d    = ones_q + {3'b000, sample_i};
      samples_d = samples_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ones_q    <= '0;
      samples_q <= '0;
    end else begin
      ones_q    <= ones_d;
      samples_q <= samples_d;
    end
  end

  assign last_o = (samples_q == LAST_IDX);
  assign vote_o = ({ones_q, 1'b0} > THRESH);

endmodule

// File: rtl/dqsw_leveling_trainer.sv
// DQSW write-leveling sweep controller: steps the IOD delay line until a stable
// 0->1 on the returned DQ. Optional eye-monitor retries: `define DQSW_EYE_MONITOR_EN.
module dqsw_leveling_trainer
  import dqsw_trainer_pkg::*;
#(
  parameter int unsigned TAP_W         = 8,
  parameter int unsigned MAX_TAPS      = 255,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_COUNT  = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic [1:0]       TX_DATA,
  output logic [1:0]       OE_DATA,
  input  logic [1:0]       RX_DATA,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS);

  state_e           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] tap_count_q, tap_count_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             seen_zero_q, seen_zero_d;

  logic voter_clear, voter_capture, voter_sample, vote, last_sample;
  logic unused_bits;

`ifdef DQSW_EYE_MONITOR_EN
  logic [1:0] retry_q, retry_d;
  logic       eye_flag;
  assign eye_flag    = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
  assign unused_bits = RX_DATA[1];
`else
  assign unused_bits = ^{RX_DATA[1], EYE_MONITOR_EARLY, EYE_MONITOR_LATE};
`endif

  dqsw_sample_voter #(
    .SAMPLE_COUNT(SAMPLE_COUNT)
  ) u_voter (
    .clk_i    (FAB_CLK),
    .rst_i    (RESET),
    .clear_i  (voter_clear),
    .capture_i(voter_capture),
    .sample_i (voter_sample),
    .vote_o   (vote),
    .last_o   (last_sample)
  );

  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    tap_count_d   = tap_count_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    fail_d        = fail_q;
    seen_zero_d   = seen_zero_q;
    voter_clear   = 1'b0;
    voter_capture = 1'b0;
    voter_sample  = RX_DATA[0];
`ifdef DQSW_EYE_MONITOR_EN
    retry_d       = retry_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          done_d      = 1'b0;
          fail_d      = 1'b0;
          seen_zero_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        tap_d   = '0;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE, S_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == S_SETTLE) ? S_PULSE : S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_PULSE: state_d = S_WAIT;
      S_CAPTURE: begin
`ifdef DQSW_EYE_MONITOR_EN
        // A flagged sample is re-pulsed; once retries run out it is taken as 0.
        if (eye_flag && (retry_q != EYE_RETRY_LIMIT)) begin
          retry_d = retry_q + 2'd1;
          state_d = S_PULSE;
        end else begin
          retry_d       = '0;
          voter_capture = 1'b1;
          voter_sample  = RX_DATA[0] & ~eye_flag;
          state_d       = last_sample ? S_DECIDE : S_PULSE;
        end
`else
        voter_capture = 1'b1;
        state_d       = last_sample ? S_DECIDE : S_PULSE;
`endif
      end
      S_DECIDE: begin
        voter_clear = 1'b1;
        if (vote && seen_zero_q) begin
          tap_count_d = tap_q;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          if (!vote) seen_zero_d = 1'b1;
          if ((tap_q == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE) begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        tap_d   = tap_q + 1'b1;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      tap_count_q <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      seen_zero_q <= 1'b0;
`ifdef DQSW_EYE_MONITOR_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      tap_count_q <= tap_count_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      seen_zero_q <= seen_zero_d;
`ifdef DQSW_EYE_MONITOR_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign BUSY                 = (state_q != S_IDLE);
  assign DONE                 = done_q;
  assign FAIL                 = fail_q;
  assign TAP_COUNT            = tap_count_q;
  assign TX_DATA              = (state_q == S_PULSE) ? TX_PULSE : TXOE_IDLE;
  assign OE_DATA              = (state_q == S_PULSE) ? OE_PULSE : TXOE_IDLE;
  assign DELAY_LINE_LOAD      = (state_q == S_LOAD);
  assign DELAY_LINE_MOVE      = (state_q == S_MOVE);
  assign DELAY_LINE_DIRECTION = BUSY;
`ifdef DQSW_EYE_MONITOR_EN
  assign EYE_MONITOR_CLEAR_FLAGS = (state_q == S_PULSE);
`else
  assign EYE_MONITOR_CLEAR_FLAGS = 1'b0;
`endif

endmodule
